demux_dispatch_ctrl: RTL and testbench

Sequencer that owns the 1-to-8, 16-bit word demultiplexer. It accepts one word at a time from an upstream producer over a valid/ready handshake and picks a destination channel by round-robin. It drives the demux `selector` and data input, then issues a one-cycle, one-hot valid strobe to the chosen channel. It sits directly in front of the demux: `selector` and `output_data` feed the demux inputs, and `out_valid` qualifies the eight demux outputs.

---
 rtl/demux_dispatch_ctrl.sv | 134 +++++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch_ctrl.sv
// Round-robin dispatcher in front of a 1-to-8 word demux: accepts one word, picks a channel, strobes it.
// Optional DISPATCH_SKIP_BUSY_EN: scan forward from ptr for the first ready channel instead of waiting on ptr.
module demux_dispatch_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input1,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            chan_ready,
  output logic [2:0]            selector,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic [7:0]            out_valid,
  output logic                  drop,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam bit         TO_EN     = (TIMEOUT != 0);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [2:0]            ptr_q, ptr_d;
  logic [2:0]            sel_q, sel_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]            ov_q, ov_d;
  logic                  drop_q, drop_d;
  logic [7:0]            wait_q, wait_d;

  logic [2:0]            tgt_s;
  logic                  tgt_vld_s;

`ifdef DISPATCH_SKIP_BUSY_EN
  logic [2:0]            idx_s;

  // Target selection: first ready channel at or after ptr; descending scan lets the nearest win.
  always_comb begin
    tgt_s     = ptr_q;
    tgt_vld_s = 1'b0;
    idx_s     = ptr_q;
    for (int k = 7; k >= 0; k--) begin
      idx_s     = ptr_q + 3'(k);
      tgt_s     = chan_ready[idx_s] ? idx_s : tgt_s;
      tgt_vld_s = tgt_vld_s | chan_ready[idx_s];
    end
  end
`else
  // Target selection: strict round-robin waits on channel ptr only.
  always_comb begin
    tgt_s     = ptr_q;
    tgt_vld_s = chan_ready[ptr_q];
  end
`endif

  // Next-state and next-output computation for the dispatch sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    ov_d    = 8'h00;
    drop_d  = 1'b0;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = input1;
          wait_d  = 8'd0;
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      ARB: begin
        // A grant in the timeout cycle wins over the drop.
        if (tgt_vld_s) begin
          sel_d   = tgt_s;
          ov_d    = 8'h01 << tgt_s;
          state_d = SEND;
        end else if (TO_EN && (wait_q == WAIT_LAST)) begin
          drop_d  = 1'b1;
          ptr_d   = ptr_q + 3'd1;
          state_d = IDLE;
        end else begin
          wait_d  = wait_q + 8'd1;
          state_d = ARB;
        end
      end
      SEND: begin
        ptr_d   = sel_q + 3'd1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      data_q  <= '0;
      ov_q    <= 8'h00;
      drop_q  <= 1'b0;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      ov_q    <= ov_d;
      drop_q  <= drop_d;
      wait_q  <= wait_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign selector    = sel_q;
  assign output_data = data_q;
  assign out_valid   = ov_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: two instances (TIMEOUT 255 and 4) on shared inputs, each checked
// every cycle against a transaction-level model, plus directed boundary scenarios.
module tb_demux_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] input1;
  logic        in_valid;
  logic [7:0]  chan_ready;

  logic        in_ready_o    [2];
  logic [2:0]  sel_o         [2];
  logic [15:0] data_o        [2];
  logic [7:0]  ov_o          [2];
  logic        drop_o        [2];
  logic        busy_o        [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_dispatch_ctrl #(.DATA_WIDTH(16), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset(reset), .input1(input1), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .chan_ready(chan_ready), .selector(sel_o[0]), .output_data(data_o[0]), .out_valid(ov_o[0]),
    .drop(drop_o[0]), .busy(busy_o[0])
  );

  demux_dispatch_ctrl #(.DATA_WIDTH(16), .TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .input1(input1), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .chan_ready(chan_ready), .selector(sel_o[1]), .output_data(data_o[1]), .out_valid(ov_o[1]),
    .drop(drop_o[1]), .busy(busy_o[1])
  );

  // Reference model: a word is either held waiting for a channel, or being strobed.
  int          to_lim [2] = '{255, 4};
  bit          m_hold [2];
  bit          m_send [2];
  bit          m_drop [2];
  int          m_ptr  [2];
  int          m_chan [2];
  int          m_wait [2];
  int          m_sel  [2];
  logic [15:0] m_data [2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input int p, input logic [7:0] cr);
`ifdef DISPATCH_SKIP_BUSY_EN
    for (int k = 0; k < 8; k++) begin
      if (cr[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
`else
    return cr[p] ? p : -1;
`endif
  endfunction

  function automatic logic [7:0] onehot(input int k);
    logic [7:0] v;
    v = 8'h01 << k;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hold[i] = 1'b0; m_send[i] = 1'b0; m_drop[i] = 1'b0;
      m_ptr[i] = 0; m_chan[i] = 0; m_wait[i] = 0; m_sel[i] = 0; m_data[i] = 16'h0000;
    end
  endtask

  task automatic model_step(input logic iv, input logic [15:0] d, input logic [7:0] cr);
    int t;
    for (int i = 0; i < 2; i++) begin
      m_drop[i] = 1'b0;
      if (m_send[i]) begin
        m_send[i] = 1'b0;
        m_ptr[i]  = (m_chan[i] + 1) % 8;
      end else if (m_hold[i]) begin
        t = pick(m_ptr[i], cr);
        if (t >= 0) begin
          m_hold[i] = 1'b0; m_send[i] = 1'b1; m_chan[i] = t; m_sel[i] = t;
        end else if (to_lim[i] != 0 && m_wait[i] + 1 == to_lim[i]) begin
          m_hold[i] = 1'b0; m_drop[i] = 1'b1; m_ptr[i] = (m_ptr[i] + 1) % 8;
        end else begin
          m_wait[i]++;
        end
      end else if (iv) begin
        m_hold[i] = 1'b1; m_data[i] = d; m_wait[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("in_ready%0d", i), 32'(in_ready_o[i]), 32'(!(m_hold[i] || m_send[i])));
      check_eq($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(m_hold[i] || m_send[i]));
      check_eq($sformatf("out_valid%0d", i), 32'(ov_o[i]), 32'(m_send[i] ? onehot(m_chan[i]) : 8'h00));
      check_eq($sformatf("selector%0d", i), 32'(sel_o[i]), 32'(m_sel[i]));
      check_eq($sformatf("output_data%0d", i), 32'(data_o[i]), 32'(m_data[i]));
      check_eq($sformatf("drop%0d", i), 32'(drop_o[i]), 32'(m_drop[i]));
    end
  endtask

  // Drive one cycle's inputs, advance the model, then compare after the edge.
  task automatic step(input logic iv, input logic [15:0] d, input logic [7:0] cr);
    in_valid = iv; input1 = d; chan_ready = cr;
    model_step(iv, d, cr);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // Called at a negedge: asynchronous reset assertion checked before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_ff(input int n);
    for (int w = 0; w < n; w++) begin
      step(1'b1, 16'(w + 16'h0100), 8'hFF);
      step(1'b0, 16'h0000, 8'hFF);
      step(1'b0, 16'h0000, 8'hFF);
    end
  endtask

  initial begin
    int         drop_cyc;
    logic [7:0] cr;
    reset = 1'b1; in_valid = 1'b0; input1 = 16'h0000; chan_ready = 8'h00;
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b0;
    step(1'b0, 16'h0000, 8'hFF);

    // Back-to-back words with every channel ready: 3-cycle cadence, wrap after channel 7.
    for (int w = 1; w <= 9; w++) begin
      step(1'b1, 16'(w), 8'hFF);
      step(1'b1, 16'(w), 8'hFF);
      check_eq("b2b_strobe", 32'(ov_o[0]), 32'(onehot((w - 1) % 8)));
      check_eq("b2b_sel", 32'(sel_o[0]), 32'((w - 1) % 8));
      check_eq("b2b_data", 32'(data_o[0]), 32'(w));
      step(1'b1, 16'(w), 8'hFF);
      check_eq("b2b_gap", 32'(ov_o[0]), 32'h0);
    end

    // Reset while a word waits in arbitration.
    do_reset();
    send_ff(3);
    step(1'b1, 16'hA5A5, 8'h00);
    step(1'b0, 16'h0000, 8'h00);
    check_eq("pre_reset_busy", 32'(busy_o[0]), 32'h1);
    do_reset();

`ifdef DISPATCH_SKIP_BUSY_EN
    send_ff(6);
    step(1'b1, 16'hCAFE, 8'h05);
    step(1'b0, 16'h0000, 8'h05);
    check_eq("skip_strobe", 32'(ov_o[0]), 32'h01);
    step(1'b0, 16'h0000, 8'h05);
    step(1'b1, 16'h1111, 8'hFF);
    step(1'b0, 16'h0000, 8'hFF);
    check_eq("skip_next_ptr", 32'(ov_o[0]), 32'h02);
    step(1'b0, 16'h0000, 8'hFF);
`else
    send_ff(2);
    step(1'b1, 16'hBEEF, 8'h08);
    for (int c = 0; c < 5; c++) step(1'b0, 16'h0000, 8'h08);
    check_eq("strict_wait", 32'(ov_o[0]), 32'h0);
    step(1'b0, 16'h0000, 8'h0C);
    check_eq("strict_strobe", 32'(ov_o[0]), 32'h04);
    check_eq("strict_data", 32'(data_o[0]), 32'hBEEF);
    step(1'b0, 16'h0000, 8'h0C);
    step(1'b1, 16'h2222, 8'hFF);
    step(1'b0, 16'h0000, 8'hFF);
    check_eq("strict_next_ptr", 32'(ov_o[0]), 32'h08);
    step(1'b0, 16'h0000, 8'hFF);
`endif

    // Timeout drop on the TIMEOUT=4 instance.
    do_reset();
    drop_cyc = 0;
    step(1'b1, 16'h1234, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      if (drop_o[1] && drop_cyc == 0) drop_cyc = c;
      if (drop_o[1]) check_eq("drop_in_ready", 32'(in_ready_o[1]), 32'h1);
      check_eq("drop_no_strobe", 32'(ov_o[1]), 32'h0);
      step(1'b0, 16'h0000, 8'h00);
    end
    check_eq("drop_cycle", 32'(drop_cyc), 32'd5);
    step(1'b1, 16'h3333, 8'hFF);
    step(1'b0, 16'h0000, 8'hFF);
    check_eq("drop_ptr_adv", 32'(ov_o[1]), 32'h02);
    step(1'b0, 16'h0000, 8'hFF);

    // Grant arriving in the last allowed arbitration cycle wins over the drop.
    do_reset();
    step(1'b1, 16'h5678, 8'h00);
    for (int c = 0; c < 3; c++) step(1'b0, 16'h0000, 8'h00);
    step(1'b0, 16'h0000, 8'h01);
    check_eq("late_grant_strobe", 32'(ov_o[1]), 32'h01);
    check_eq("late_grant_nodrop", 32'(drop_o[1]), 32'h0);
    step(1'b0, 16'h0000, 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0:       cr = 8'h00;
        1:       cr = 8'hFF;
        default: cr = 8'($urandom & $urandom);
      endcase
      step(1'($urandom_range(0, 9) < 7), 16'($urandom), cr);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
